clock_uart_reporter: RTL

Transmit-side counterpart of the board's switch/button time entry: reads clockwork time and calendar date and reports them over a UART TX line.
On each rising edge of the 1 Hz tick it snapshots time/date and sends one ASCII frame "HH:MM:SS DD.MM.YYYY\r\n" (21 bytes), 8N1.
Sits beside clockwork/calendar on the test board; its TX pin goes to the board's USB-UART bridge.

---
 rtl/clock_uart_reporter_pkg.sv | 53 +++++
 rtl/clock_uart_reporter_uart_tx_byte.sv | 53 +++++
 rtl/clock_uart_reporter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/clock_uart_reporter_pkg.sv
// Shared constants, types and helpers for the clock/date UART reporter.
package clock_uart_reporter_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_L     = 8'h4C;

  localparam int FRAME_LEN    = 21;
  localparam int FRAME_LEN_AL = 24;
  localparam int YEAR_BITS    = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_CONV, ST_SEND} state_e;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  typedef struct packed {
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
  } date_t;

  function automatic logic [7:0] tens_char(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return ASCII_0 + {2'b00, t};
  endfunction

  function automatic logic [7:0] units_char(input logic [5:0] v);
    logic [5:0] u;
    u = v % 6'd10;
    return ASCII_0 + {2'b00, u};
  endfunction

  // One double-dabble iteration on {bcd[15:0], bin[11:0]}.
  function automatic logic [27:0] dd_step(input logic [27:0] r);
    logic [27:0] a;
    a = r;
    for (int k = 0; k < 4; k++) begin
      if (a[12+4*k +: 4] >= 4'd5) a[12+4*k +: 4] = a[12+4*k +: 4] + 4'd3;
    end
    return {a[26:0], 1'b0};
  endfunction

endpackage

// File: rtl/clock_uart_reporter_uart_tx_byte.sv
// 8N1 byte transmitter; ready rises in the last stop-bit cycle so bytes go back to back.
module uart_tx_byte #(
  parameter int DIV = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [9:0]    shift_q;
  logic          active_q;
  logic          last_cyc;
  logic          accept;

  assign last_cyc = active_q && (bit_q == 4'd0) && (baud_q == '0);
  assign ready_o  = ~active_q | last_cyc;
  assign accept   = valid_i & ready_o;
  assign tx_o     = active_q ? shift_q[0] : 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= '1;
      active_q <= 1'b0;
    end else if (accept) begin
      shift_q  <= {1'b1, data_i, 1'b0};
      bit_q    <= 4'd9;
      baud_q   <= CW'(DIV - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (baud_q == '0) begin
        if (bit_q == 4'd0) begin
          active_q <= 1'b0;
        end else begin
          shift_q <= {1'b1, shift_q[9:1]};
          bit_q   <= bit_q - 4'd1;
          baud_q  <= CW'(DIV - 1);
        end
      end else begin
        baud_q <= baud_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_uart_reporter.sv
// Sends "HH:MM:SS DD.MM.YYYY\r\n" on every 1 Hz tick edge.
// Define ALARM_FLAG_EN to append " AL" when the snapshotted ring flag is set.
module clock_uart_reporter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        tick_1hz_i,
  input  logic [16:0] time_i,
  input  logic [20:0] date_i,
  input  logic        ring_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        overrun_o
);
  import clock_uart_reporter_pkg::*;

  localparam int DIV = CLK_FREQ / BAUD;

  state_e      state_q, state_d;
  logic        tick_d_q;
  logic        overrun_q;
  time_t       time_q;
  date_t       date_q;
  logic [27:0] dd_q;
  logic [3:0]  iter_q;
  logic [4:0]  idx_q;
  logic        ring_w;
  logic [4:0]  len_w;
  logic        start_w;
  logic        valid_w;
  logic        ready_w;
  logic [7:0]  char_w;

`ifdef ALARM_FLAG_EN
  logic ring_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             ring_q <= 1'b0;
    else if (state_q == ST_IDLE && start_w)  ring_q <= ring_i;
  end
  assign ring_w = ring_q;
`else
  logic unused_ring;
  assign unused_ring = ring_i;
  assign ring_w      = 1'b0;
`endif

  assign start_w   = tick_1hz_i & ~tick_d_q & en_i;
  assign len_w     = ring_w ? 5'(FRAME_LEN_AL) : 5'(FRAME_LEN);
  assign busy_o    = (state_q != ST_IDLE);
  assign overrun_o = overrun_q;

  always_comb begin
    state_d = state_q;
    valid_w = 1'b0;
    case (state_q)
      ST_IDLE: if (start_w) state_d = ST_SNAP;
      ST_SNAP: state_d = ST_CONV;
      ST_CONV: if (iter_q == 4'd0) state_d = ST_SEND;
      ST_SEND: begin
        if (idx_q == len_w) begin
          if (ready_w) state_d = ST_IDLE;
        end else begin
          valid_w = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // tick_d resets high so a tick already high at release is not taken as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_d_q  <= 1'b1;
      overrun_q <= 1'b0;
      time_q    <= '0;
      date_q    <= '0;
      dd_q      <= '0;
      iter_q    <= 4'd0;
      idx_q     <= 5'd0;
    end else begin
      tick_d_q <= tick_1hz_i;
      if (start_w) begin
        if (state_q == ST_IDLE) begin
          time_q <= time_t'(time_i);
          date_q <= date_t'(date_i);
        end else begin
          overrun_q <= 1'b1;
        end
      end
      case (state_q)
        ST_SNAP: begin
          dd_q   <= {16'd0, date_q.year};
          iter_q <= 4'(YEAR_BITS - 1);
          idx_q  <= 5'd0;
        end
        ST_CONV: begin
          dd_q   <= dd_step(dd_q);
          iter_q <= iter_q - 4'd1;
        end
        ST_SEND: if (valid_w && ready_w) idx_q <= idx_q + 5'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    char_w = ASCII_SPACE;
    case (idx_q)
      5'd0:  char_w = tens_char({1'b0, time_q.hour});
      5'd1:  char_w = units_char({1'b0, time_q.hour});
      5'd2:  char_w = ASCII_COLON;
      5'd3:  char_w = tens_char(time_q.min);
      5'd4:  char_w = units_char(time_q.min);
      5'd5:  char_w = ASCII_COLON;
      5'd6:  char_w = tens_char(time_q.sec);
      5'd7:  char_w = units_char(time_q.sec);
      5'd8:  char_w = ASCII_SPACE;
      5'd9:  char_w = tens_char({1'b0, date_q.day});
      5'd10: char_w = units_char({1'b0, date_q.day});
      5'd11: char_w = ASCII_DOT;
      5'd12: char_w = tens_char({2'b00, date_q.month});
      5'd13: char_w = units_char({2'b00, date_q.month});
      5'd14: char_w = ASCII_DOT;
      5'd15: char_w = ASCII_0 + {4'd0, dd_q[27:24]};
      5'd16: char_w = ASCII_0 + {4'd0, dd_q[23:20]};
      5'd17: char_w = ASCII_0 + {4'd0, dd_q[19:16]};
      5'd18: char_w = ASCII_0 + {4'd0, dd_q[15:12]};
      5'd19: char_w = ring_w ? ASCII_SPACE : ASCII_CR;
      5'd20: char_w = ring_w ? ASCII_A : ASCII_LF;
      5'd21: char_w = ASCII_L;
      5'd22: char_w = ASCII_CR;
      5'd23: char_w = ASCII_LF;
      default: char_w = ASCII_SPACE;
    endcase
  end

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (char_w),
    .valid_i (valid_w),
    .ready_o (ready_w),
    .tx_o    (tx_o)
  );

endmodule
